// File: rtl/serializador_pkg.sv
// serializador_pkg: shared state type and constants for the byte serializer.
// Optional HOLD support is selected with SERIALIZADOR_TX_HOLD_EN.
package serializador_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        BIT_HI,
        BIT_LO,
        GAP
    } ser_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ser_timer.sv
// ser_timer: loadable down-counter; expire is high while the count sits at zero.
// A phase of N cycles is timed by loading N-1 on entry.
import serializador_pkg::*;

module ser_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/serializador.sv
// serializador: MSB-first byte transmitter with per-bit write strobe and byte gap.
// Define SERIALIZADOR_TX_HOLD_EN to defer transmission while status_busy is high.
import serializador_pkg::*;

module serializador #(
    parameter int HALF_PERIOD = 10,
    parameter int BYTE_GAP    = 20
) (
    input  logic              clock1MHz,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              load,
    input  logic              status_busy,
    output logic              ready,
    output logic              data_serial,
    output logic              write_serial,
    output logic              done
);

    localparam int TW = $clog2(max_int(HALF_PERIOD, BYTE_GAP) + 1);
    localparam logic [TW-1:0] HP_M1 = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] BG_M1 = TW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    ser_state_t        state;
    logic [BYTE_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tmr_load;
    logic [TW-1:0]     tmr_value;
    logic              tmr_expire;

`ifndef SERIALIZADOR_TX_HOLD_EN
    logic unused_busy;
    assign unused_busy = status_busy;
`endif

    // Timer is preloaded while waiting, and reloaded on every phase change.
    always_comb begin
        tmr_load  = tmr_expire || (state == IDLE) || (state == HOLD);
        tmr_value = HP_M1;
        if (state == BIT_LO && bit_cnt == LAST_BIT) begin
            tmr_value = BG_M1;
        end
    end

    ser_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clock1MHz),
        .rst_n (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .expire(tmr_expire)
    );

    // Outputs follow the state one cycle later; ready low in IDLE marks the done cycle.
    always_ff @(posedge clock1MHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            ready        <= 1'b1;
            data_serial  <= 1'b0;
            write_serial <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    write_serial <= 1'b0;
                    data_serial  <= 1'b0;
                    if (!ready) begin
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end else if (load) begin
                        ready   <= 1'b0;
                        shift   <= data_in;
                        bit_cnt <= '0;
`ifdef SERIALIZADOR_TX_HOLD_EN
                        state <= status_busy ? HOLD : BIT_HI;
`else
                        state <= BIT_HI;
`endif
                    end
                end
`ifdef SERIALIZADOR_TX_HOLD_EN
                HOLD: begin
                    write_serial <= 1'b0;
                    data_serial  <= 1'b0;
                    if (!status_busy) begin
                        state <= BIT_HI;
                    end
                end
`endif
                BIT_HI: begin
                    write_serial <= 1'b1;
                    data_serial  <= shift[BYTE_W-1];
                    if (tmr_expire) begin
                        state <= BIT_LO;
                    end
                end
                BIT_LO: begin
                    write_serial <= 1'b0;
                    data_serial  <= shift[BYTE_W-1];
                    if (tmr_expire) begin
                        shift   <= {shift[BYTE_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt != LAST_BIT) begin
                            state <= BIT_HI;
                        end else if (BYTE_GAP > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    write_serial <= 1'b0;
                    data_serial  <= 1'b0;
                    if (tmr_expire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador.sv
// tb_serializador: scoreboard bench; expected strobes and done pulses are queued
// from the byte timing rules and checked by per-DUT monitors.
module tb_serializador;

    localparam int HP_A = 10;
    localparam int BG_A = 20;
    localparam int HP_B = 2;
    localparam int BG_B = 0;

    typedef struct {
        logic b;
        int   cyc;
    } strobe_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_a, data_b;
    logic       load_a, load_b;
    logic       status_busy, busy_b;
    logic       ready_a, ds_a, ws_a, done_a;
    logic       ready_b, ds_b, ws_b, done_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    strobe_t sqa[$];
    strobe_t sqb[$];
    int      dqa[$];
    int      dqb[$];

    serializador #(.HALF_PERIOD(HP_A), .BYTE_GAP(BG_A)) dut_a (
        .clock1MHz   (clk),
        .reset       (rst_n),
        .data_in     (data_a),
        .load        (load_a),
        .status_busy (status_busy),
        .ready       (ready_a),
        .data_serial (ds_a),
        .write_serial(ws_a),
        .done        (done_a)
    );

    serializador #(.HALF_PERIOD(HP_B), .BYTE_GAP(BG_B)) dut_b (
        .clock1MHz   (clk),
        .reset       (rst_n),
        .data_in     (data_b),
        .load        (load_b),
        .status_busy (busy_b),
        .ready       (ready_b),
        .data_serial (ds_b),
        .write_serial(ws_b),
        .done        (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Bit n of a byte starting at edge s rises after edge s+1+2n*HP.
    task automatic expect_byte(input bit sel, input logic [7:0] b, input int s,
                               input int nb, input bit with_done);
        int hp, bg;
        strobe_t e;
        hp = sel ? HP_B : HP_A;
        bg = sel ? BG_B : BG_A;
        for (int n = 0; n < nb; n++) begin
            e.b   = b[7-n];
            e.cyc = s + 1 + 2 * n * hp;
            if (sel) sqb.push_back(e);
            else sqa.push_back(e);
        end
        if (with_done) begin
            if (sel) dqb.push_back(s + 1 + 16 * hp + bg);
            else dqa.push_back(s + 1 + 16 * hp + bg);
        end
    endtask

    strobe_t ea, eb;
    int      hia, hib;
    logic    ws_qa = 1'b0;
    logic    ws_qb = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ws_qa = 1'b0;
        end else begin
            if (ws_a && !ws_qa) begin
                chk("a_strobe_expected", int'(sqa.size() > 0), 1);
                if (sqa.size() > 0) begin
                    ea = sqa.pop_front();
                    chk("a_bit", int'(ds_a), int'(ea.b));
                    chk("a_rise_cycle", cyc, ea.cyc);
                end
                hia = 0;
            end
            if (ws_a) hia++;
            if (!ws_a && ws_qa) chk("a_high_width", hia, HP_A);
            if (done_a) begin
                chk("a_done_expected", int'(dqa.size() > 0), 1);
                if (dqa.size() > 0) chk("a_done_cycle", cyc, dqa.pop_front());
                chk("a_ready_at_done", int'(ready_a), 1);
                chk("a_ws_at_done", int'(ws_a), 0);
            end
            ws_qa = ws_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ws_qb = 1'b0;
        end else begin
            if (ws_b && !ws_qb) begin
                chk("b_strobe_expected", int'(sqb.size() > 0), 1);
                if (sqb.size() > 0) begin
                    eb = sqb.pop_front();
                    chk("b_bit", int'(ds_b), int'(eb.b));
                    chk("b_rise_cycle", cyc, eb.cyc);
                end
                hib = 0;
            end
            if (ws_b) hib++;
            if (!ws_b && ws_qb) chk("b_high_width", hib, HP_B);
            if (done_b) begin
                chk("b_done_expected", int'(dqb.size() > 0), 1);
                if (dqb.size() > 0) chk("b_done_cycle", cyc, dqb.pop_front());
                chk("b_ready_at_done", int'(ready_b), 1);
            end
            ws_qb = ws_b;
        end
    end

    // spur: 0 none, 1 one 0xFF load pulse at bit 4, 2 random load pulses.
    task automatic xmit(input logic [7:0] b, input int hold, input int spur);
        int k, s, dn;
        @(negedge clk);
        chk("a_ready_before_load", int'(ready_a), 1);
        load_a = 1'b1;
        data_a = b;
        status_busy = (hold > 0);
        @(negedge clk);
        k = cyc;
        load_a = 1'b0;
        data_a = 8'($urandom);
        s = k;
`ifdef SERIALIZADOR_TX_HOLD_EN
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            status_busy = 1'b0;
            s = cyc + 1;
        end
`endif
        expect_byte(1'b0, b, s, 8, 1'b1);
        dn = s + 1 + 16 * HP_A + BG_A;
        while (cyc < dn) begin
            @(negedge clk);
            load_a = 1'b0;
            status_busy = 1'($urandom_range(0, 1));
            if (cyc < dn && ((spur == 1 && cyc == s + 1 + 8 * HP_A) ||
                             (spur == 2 && $urandom_range(0, 15) == 0))) begin
                load_a = 1'b1;
                data_a = 8'hFF;
            end
        end
        load_a = 1'b0;
        status_busy = 1'b0;
    endtask

    initial begin
        int k, k2;
        rst_n = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        data_a = '0;
        data_b = '0;
        status_busy = 1'b0;
        busy_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", int'(ready_a), 1);
        chk("reset_ws", int'(ws_a), 0);
        chk("reset_ds", int'(ds_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_ready_b", int'(ready_b), 1);
        rst_n = 1'b1;

        // Zero gap, load held high: second byte taken one edge after done.
        @(negedge clk);
        load_b = 1'b1;
        data_b = 8'h55;
        @(negedge clk);
        k = cyc;
        data_b = 8'hAA;
        expect_byte(1'b1, 8'h55, k, 8, 1'b1);
        k2 = k + 1 + 16 * HP_B + BG_B + 1;
        expect_byte(1'b1, 8'hAA, k2, 8, 1'b1);
        while (cyc < k2) @(negedge clk);
        load_b = 1'b0;
        while (cyc < k2 + 16 * HP_B + BG_B + 3) @(negedge clk);

        xmit(8'hA5, 0, 0);
        xmit(8'h3C, 0, 1);
        xmit(8'h81, 100, 0);

        // Reset in the middle of bit 3 of 0xF0 (a '1' bit).
        @(negedge clk);
        load_a = 1'b1;
        data_a = 8'hF0;
        @(negedge clk);
        k = cyc;
        load_a = 1'b0;
        expect_byte(1'b0, 8'hF0, k, 4, 1'b0);
        while (cyc < k + 1 + 6 * HP_A + 3) @(negedge clk);
        chk("pre_reset_ds", int'(ds_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_ws", int'(ws_a), 0);
        chk("midreset_ds", int'(ds_a), 0);
        chk("midreset_done", int'(done_a), 0);
        chk("midreset_ready", int'(ready_a), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", int'(ready_a), 1);
        xmit(8'h0F, 0, 0);

        for (int i = 0; i < 5; i++) begin
            xmit(8'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0, 2);
        end

        repeat (10) @(negedge clk);
        chk("a_strobes_left", sqa.size(), 0);
        chk("a_dones_left", dqa.size(), 0);
        chk("b_strobes_left", sqb.size(), 0);
        chk("b_dones_left", dqb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
